relay_station_mc: RTL and testbench

- Multi-channel, floorplan-friendly first-word fall-through (FWFT) relay station.
- Carries NUM_CH independent streams across a long route. Each stream passes through LEVEL register stages into a per-channel almost-full FIFO at the read end.
- Adds per-channel runtime enable, synchronous flush, a sticky overflow flag and occupancy reporting.
- Drops in between task ports where several parallel FIFOs cross the same slot boundary.

---
 rtl/relay_station_mc_pkg.sv | 30 +++
 rtl/relay_af_fifo.sv | 125 ++++++++++++
 rtl/relay_station_mc.sv | 122 ++++++++++++
 tb/tb_relay_station_mc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_station_mc_pkg.sv
// relay_station_mc_pkg
//   Shared sizing helpers for the multi-channel relay station.
//   - calc_grace      : backpressure round-trip slack (2*LEVEL)
//   - calc_real_depth : physical FIFO entries (DEPTH + GRACE + 4)
//   - calc_cnt_w      : width of a 0..REAL_DEPTH occupancy counter
//   - calc_ptr_w      : width of a 0..REAL_DEPTH-1 pointer
//   - ch_lsb          : LSB of channel c in a flattened per-channel bus
package relay_station_mc_pkg;

  function automatic int calc_grace(input int level);
    return level + level;
  endfunction

  function automatic int calc_real_depth(input int depth, input int level);
    return depth + calc_grace(level) + 32'sd4;
  endfunction

  function automatic int calc_cnt_w(input int real_depth);
    return $clog2(real_depth + 32'sd1);
  endfunction

  function automatic int calc_ptr_w(input int real_depth);
    return (real_depth > 32'sd1) ? $clog2(real_depth) : 32'sd1;
  endfunction

  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/relay_af_fifo.sv
// relay_af_fifo
//   Single-channel register-based FWFT FIFO with an almost-full flag.
//   Pointers wrap modulo REAL_DEPTH, so non-power-of-two depths work.
//   Optional macro RELAY_STATION_MC_PEAK_EN: occupancy reports the
//   high-water mark (cleared by reset or flush) instead of the live count.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             synchronous clear of count/pointers (overflow kept)
//   push, push_data   beat arriving from the last pipeline stage
//   pop               consumer pop (already qualified by the caller)
//   dout, empty_n     FWFT head data and valid
//   af                almost-full: count >= REAL_DEPTH-1-GRACE
//   occupancy         live count (or peak, see macro)
//   overflow          sticky: a beat arrived while full with no pop
module relay_af_fifo
  import relay_station_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REAL_DEPTH = 10,
  parameter int GRACE      = 4,
  parameter int CNT_W      = 4,
  localparam int PTR_W     = calc_ptr_w(REAL_DEPTH),
  localparam int AF_THR    = REAL_DEPTH - 32'sd1 - GRACE
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty_n,
  output logic                  af,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem_r [REAL_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic                  ovf_r;
  logic                  full_s;
  logic                  do_push_s;
  logic                  do_pop_s;
  logic                  drop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(REAL_DEPTH - 32'sd1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // Push/pop qualification and next count; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    full_s      = (count_r == CNT_W'(REAL_DEPTH));
    do_pop_s    = pop & (count_r != '0);
    do_push_s   = push & (~full_s | do_pop_s);
    drop_s      = push & full_s & ~do_pop_s;
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers, count and sticky overflow; flush leaves the overflow flag alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      ovf_r    <= 1'b0;
      for (int i = 0; i < REAL_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      ovf_r    <= ovf_r;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_r | drop_s;
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  assign dout     = mem_r[rd_ptr_r];
  assign empty_n  = (count_r != '0);
  assign af       = (count_r >= CNT_W'(AF_THR));
  assign overflow = ovf_r;

`ifdef RELAY_STATION_MC_PEAK_EN
  logic [CNT_W-1:0] peak_r;

  // High-water mark follows the next count so it lines up with the live counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_r <= '0;
    end else if (flush) begin
      peak_r <= '0;
    end else if (count_nxt_s > peak_r) begin
      peak_r <= count_nxt_s;
    end else begin
      peak_r <= peak_r;
    end
  end

  assign occupancy = peak_r;
`else
  assign occupancy = count_r;
`endif

endmodule

// File: rtl/relay_station_mc.sv
// relay_station_mc
//   NUM_CH independent FWFT relay stations. Each channel runs LEVEL register
//   stages forward (data+valid) and LEVEL stages backward (not-full) around
//   an almost-full FIFO whose GRACE slack absorbs the 2*LEVEL round trip.
//   Optional macro RELAY_STATION_MC_PEAK_EN: occupancy shows the per-channel
//   high-water mark instead of the live count (port list unchanged).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   chan_en[c]      0 hides the channel (full_n=0, empty_n=0, pops ignored)
//   flush[c]        synchronous clear of FIFO and in-flight beats
//   if_write/if_din producer side, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   if_full_n       producer may write
//   if_read         consumer pop
//   if_empty_n/if_dout  FWFT head valid/data
//   occupancy       per-channel count, CNT_W bits each
//   err_overflow    sticky per-channel overflow
module relay_station_mc
  import relay_station_mc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int LEVEL       = 2,
  parameter int DEPTH       = 2,
  localparam int GRACE      = calc_grace(LEVEL),
  localparam int REAL_DEPTH = calc_real_depth(DEPTH, LEVEL),
  localparam int CNT_W      = calc_cnt_w(REAL_DEPTH)
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            chan_en,
  input  logic [NUM_CH-1:0]            flush,
  input  logic [NUM_CH-1:0]            if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] if_din,
  output logic [NUM_CH-1:0]            if_full_n,
  input  logic [NUM_CH-1:0]            if_read,
  output logic [NUM_CH-1:0]            if_empty_n,
  output logic [NUM_CH*DATA_WIDTH-1:0] if_dout,
  output logic [NUM_CH*CNT_W-1:0]      occupancy,
  output logic [NUM_CH-1:0]            err_overflow
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int DLSB = ch_lsb(c, DATA_WIDTH);
    localparam int OLSB = ch_lsb(c, CNT_W);

    logic                  wr_vld_s;
    logic [DATA_WIDTH-1:0] wr_dat_s;
    logic                  af_s;
    logic                  nfull_s;
    logic                  raw_empty_n_s;
    logic                  pop_s;

    // if_full_n is a flow-control hint: a producer that ignores it still
    // sends its beat down the pipe, which is how err_overflow can trip.
    if (LEVEL > 0) begin : g_pipe
      logic [LEVEL-1:0]      vld_r;
      logic [DATA_WIDTH-1:0] dat_r [LEVEL];
      logic [LEVEL-1:0]      bp_r;

      // Forward stages; flush kills every in-flight valid including this cycle's input.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_r <= '0;
          for (int i = 0; i < LEVEL; i++) begin
            dat_r[i] <= '0;
          end
        end else begin
          vld_r[0] <= if_write[c] & ~flush[c];
          dat_r[0] <= if_din[DLSB +: DATA_WIDTH];
          for (int i = 1; i < LEVEL; i++) begin
            vld_r[i] <= vld_r[i-1] & ~flush[c];
            dat_r[i] <= dat_r[i-1];
          end
        end
      end

      // Backward stages carry ~af regardless of chan_en so re-enable resumes from live state.
      always_ff @(posedge clk) begin
        if (reset) begin
          bp_r <= '1;
        end else begin
          bp_r[0] <= ~af_s;
          for (int i = 1; i < LEVEL; i++) begin
            bp_r[i] <= bp_r[i-1];
          end
        end
      end

      assign wr_vld_s = vld_r[LEVEL-1];
      assign wr_dat_s = dat_r[LEVEL-1];
      assign nfull_s  = bp_r[LEVEL-1];
    end else begin : g_direct
      assign wr_vld_s = if_write[c];
      assign wr_dat_s = if_din[DLSB +: DATA_WIDTH];
      assign nfull_s  = ~af_s;
    end

    assign pop_s         = if_read[c] & chan_en[c] & raw_empty_n_s;
    assign if_full_n[c]  = nfull_s & chan_en[c];
    assign if_empty_n[c] = raw_empty_n_s & chan_en[c];

    relay_af_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .REAL_DEPTH (REAL_DEPTH),
      .GRACE      (GRACE),
      .CNT_W      (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush[c]),
      .push      (wr_vld_s),
      .push_data (wr_dat_s),
      .pop       (pop_s),
      .dout      (if_dout[DLSB +: DATA_WIDTH]),
      .empty_n   (raw_empty_n_s),
      .af        (af_s),
      .occupancy (occupancy[OLSB +: CNT_W]),
      .overflow  (err_overflow[c])
    );
  end

endmodule

// File: tb/tb_relay_station_mc.sv
// Directed bench for relay_station_mc (NUM_CH=2, DW=32, LEVEL=2, DEPTH=2,
// REAL_DEPTH=10, CNT_W=4). Stimulus pushes expected beats into per-channel
// queues; a negedge monitor pops and compares on every qualified read.
module tb_relay_station_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  chan_en;
  logic [1:0]  flush;
  logic [1:0]  if_write;
  logic [63:0] if_din;
  logic [1:0]  if_full_n;
  logic [1:0]  if_read;
  logic [1:0]  if_empty_n;
  logic [63:0] if_dout;
  logic [7:0]  occupancy;
  logic [1:0]  err_overflow;

  int total = 0;
  int bad   = 0;
  int nacc;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_v0;
  logic [31:0] exp_v1;

  relay_station_mc dut (
    .clk          (clk),
    .reset        (reset),
    .chan_en      (chan_en),
    .flush        (flush),
    .if_write     (if_write),
    .if_din       (if_din),
    .if_full_n    (if_full_n),
    .if_read      (if_read),
    .if_empty_n   (if_empty_n),
    .if_dout      (if_dout),
    .occupancy    (occupancy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int c, input logic [31:0] v);
    if_din[c*32 +: 32] = v;
  endtask

  // Scoreboard monitor: every qualified read must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (if_read[0] && if_empty_n[0]) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL mon_ch0 unexpected beat act=%0h exp=none", if_dout[31:0]);
        end else begin
          exp_v0 = exp_q0.pop_front();
          chk("mon_ch0", {32'd0, if_dout[31:0]}, {32'd0, exp_v0});
        end
      end
      if (if_read[1] && if_empty_n[1]) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL mon_ch1 unexpected beat act=%0h exp=none", if_dout[63:32]);
        end else begin
          exp_v1 = exp_q1.pop_front();
          chk("mon_ch1", {32'd0, if_dout[63:32]}, {32'd0, exp_v1});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; chan_en = 2'b11; flush = 2'b00;
    if_write = 2'b00; if_read = 2'b00; if_din = '0;
    repeat (3) tick();
    chk("rst_full_n",  if_full_n,    2'b11);
    chk("rst_empty_n", if_empty_n,   2'b00);
    chk("rst_dout",    if_dout,      64'd0);
    chk("rst_occ",     occupancy,    8'd0);
    chk("rst_err",     err_overflow, 2'b00);
    reset = 1'b0;
    repeat (2) tick();

    // Single beat: written cycle 0, visible cycle 3, gone cycle 4.
    tick();
    if_write[0] = 1'b1; set_din(0, 32'hA5); exp_q0.push_back(32'hA5);
    tick();
    if_write[0] = 1'b0;
    chk("single_c1_empty", if_empty_n[0], 1'b0);
    tick();
    chk("single_c2_empty", if_empty_n[0], 1'b0);
    tick();
    chk("single_c3_empty", if_empty_n[0], 1'b1);
    chk("single_c3_dout",  if_dout[31:0], 32'hA5);
    chk("single_c3_occ",   occupancy[3:0], 4'd1);
    if_read[0] = 1'b1;
    tick();
    if_read[0] = 1'b0;
    chk("single_c4_empty", if_empty_n[0], 1'b0);
    chk("single_c4_occ",   occupancy[3:0], 4'd0);
    repeat (2) tick();

    // Backpressure: obedient producer, stalled consumer -> 9 accepted.
    for (int v = 1; v <= 9; v++) exp_q0.push_back(32'(v));
    nacc = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 8) chk("bp_c8_full_n", if_full_n[0], 1'b1);
      if (k == 9) chk("bp_c9_full_n", if_full_n[0], 1'b0);
      if_write[0] = if_full_n[0];
      if (if_full_n[0]) begin
        nacc++;
        set_din(0, 32'(nacc));
      end
    end
    tick();
    if_write[0] = 1'b0;
    chk("bp_accepted", 64'(nacc), 64'd9);
    repeat (4) tick();
    chk("bp_occ",    occupancy[3:0], 4'd9);
    chk("bp_err",    err_overflow, 2'b00);
    chk("bp_full_n", if_full_n[0], 1'b0);
    if_read[0] = 1'b1;
    repeat (12) tick();
    if_read[0] = 1'b0;
    chk("bp_drain_occ", occupancy[3:0], 4'd0);
    chk("bp_drain_q",   64'(exp_q0.size()), 64'd0);
    repeat (3) tick();

    // Overflow: 12 forced writes, no reads -> 10 kept, 2 dropped.
    for (int k = 0; k < 10; k++) exp_q0.push_back(32'h100 + 32'(k));
    for (int k = 0; k < 12; k++) begin
      tick();
      if_write[0] = 1'b1; set_din(0, 32'h100 + 32'(k));
    end
    tick();
    if_write[0] = 1'b0;
    repeat (4) tick();
    chk("ovf_occ",     occupancy[3:0], 4'd10);
    chk("ovf_err0",    err_overflow[0], 1'b1);
    chk("ovf_err1",    err_overflow[1], 1'b0);
    chk("ovf_full_n",  if_full_n[0], 1'b0);
    if_read[0] = 1'b1;
    repeat (13) tick();
    if_read[0] = 1'b0;
    chk("ovf_drain_q", 64'(exp_q0.size()), 64'd0);
    chk("ovf_sticky",  err_overflow[0], 1'b1);
    repeat (2) tick();

    // Disable: ch1 holds 3 beats, hidden while disabled, delivered after.
    for (int k = 0; k < 3; k++) begin
      tick();
      if_write[1] = 1'b1; set_din(1, 32'h201 + 32'(k)); exp_q1.push_back(32'h201 + 32'(k));
    end
    tick();
    if_write[1] = 1'b0;
    repeat (4) tick();
    chk("dis_pre_empty", if_empty_n[1], 1'b1);
    chk("dis_pre_occ",   occupancy[7:4], 4'd3);
    chan_en[1] = 1'b0;
    #1;
    chk("dis_empty",  if_empty_n[1], 1'b0);
    chk("dis_full_n", if_full_n[1],  1'b0);
    if_read[1] = 1'b1;
    repeat (3) tick();
    chk("dis_occ", occupancy[7:4], 4'd3);
    if_read[1] = 1'b0;
    tick();
    chan_en[1] = 1'b1;
    #1;
    chk("reen_empty", if_empty_n[1], 1'b1);
    if_read[1] = 1'b1;
    repeat (5) tick();
    if_read[1] = 1'b0;
    chk("reen_occ", occupancy[7:4], 4'd0);
    chk("reen_q",   64'(exp_q1.size()), 64'd0);
    repeat (2) tick();

    // Flush ch0 with 4 stored + 2 in flight while ch1 streams.
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 6) chk("fl_pre_occ", occupancy[3:0], 4'd4);
      if (k == 7) begin
        chk("fl_occ",   occupancy[3:0], 4'd0);
        chk("fl_empty", if_empty_n[0],  1'b0);
        if_read[0] = 1'b1;
      end
      if_write[0] = (k < 6);
      set_din(0, 32'h301 + 32'(k));
      flush[0] = (k == 6);
      if_write[1] = 1'b1; set_din(1, 32'h401 + 32'(k)); exp_q1.push_back(32'h401 + 32'(k));
      if_read[1] = 1'b1;
    end
    tick();
    if_write = 2'b00;
    repeat (6) tick();
    if_read = 2'b00;
    chk("fl_post_empty", if_empty_n[0], 1'b0);
    chk("fl_post_occ",   occupancy[3:0], 4'd0);
    chk("fl_ch1_q",      64'(exp_q1.size()), 64'd0);
    chk("fl_err_sticky", err_overflow[0], 1'b1);
    repeat (2) tick();

    // Reset mid-stream: in-flight beats must vanish.
    for (int k = 0; k < 3; k++) begin
      tick();
      if_write = 2'b11;
      set_din(0, 32'h501 + 32'(k));
      set_din(1, 32'h601 + 32'(k));
    end
    tick();
    if_write = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_full_n",  if_full_n,    2'b11);
    chk("mrst_empty_n", if_empty_n,   2'b00);
    chk("mrst_dout",    if_dout,      64'd0);
    chk("mrst_occ",     occupancy,    8'd0);
    chk("mrst_err",     err_overflow, 2'b00);
    if_read = 2'b11;
    repeat (8) tick();
    if_read = 2'b00;
    chk("mrst_late_empty", if_empty_n, 2'b00);
    chk("final_q0", 64'(exp_q0.size()), 64'd0);
    chk("final_q1", 64'(exp_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
